// File: rtl/joybus_frame_rx_pkg.sv
// Shared joybus receive definitions: FSM encoding, 50 MHz timing,
// console command codes and small elaboration helpers.
package joybus_frame_rx_pkg;

   typedef enum logic [2:0] {
      JB_S_IDLE    = 3'd0,
      JB_S_HEAD    = 3'd1,
      JB_S_PAYLOAD = 3'd2,
      JB_S_STOP    = 3'd3,
      JB_S_DONE    = 3'd4
   } jb_state_e;

   localparam int JB_US_CYC = 50;

   localparam logic [7:0] JB_CMD_STATUS = 8'h00;
   localparam logic [7:0] JB_CMD_POLL   = 8'h01;

   function automatic int jb_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/joybus_bit_sampler.sv
// Joybus line front end: 2-flop synchroniser, falling-edge detect
// and a per-bit timer that yields the sample strobe and timeout.
module joybus_bit_sampler
   import joybus_frame_rx_pkg::*;
#(
   parameter int SAMPLE_CYC  = 2 * JB_US_CYC,
   parameter int TIMEOUT_CYC = 5 * JB_US_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic din_i,
   input  logic active_i,
   output logic fall_o,
   output logic sample_stb_o,
   output logic sample_val_o,
   output logic timeout_o
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] T_SMP = TW'(SAMPLE_CYC);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);

   logic          sync1_q;
   logic          sync2_q;
   logic          prev_q;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic [TW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         timer_q <= '0;
      end else begin
         sync1_q <= din_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         timer_q <= timer_d;
      end
   end

   assign fall_o = prev_q & ~sync2_q;

   // cnt is the age of the current bit: 0 in the cycle the fall is seen
   always_comb begin
      cnt     = fall_o ? '0 : timer_q;
      timer_d = '0;
      if (active_i || fall_o) begin
         timer_d = (cnt == T_MAX) ? cnt : cnt + TW'(1);
      end
   end

   assign sample_stb_o = active_i & ~fall_o & (cnt == T_SMP);
   assign sample_val_o = sync2_q;
   assign timeout_o    = active_i & ~fall_o & (cnt == T_MAX);

endmodule

// File: rtl/joybus_frame_rx.sv
// Joybus frame receiver: skips the console header, shifts in the
// controller payload, checks the stop bit and reports the word.
module joybus_frame_rx
   import joybus_frame_rx_pkg::*;
#(
   parameter int HEAD_BITS    = 9,
   parameter int PAYLOAD_BITS = 32,
   parameter int SAMPLE_CYC   = 2 * JB_US_CYC,
   parameter int TIMEOUT_CYC  = 5 * JB_US_CYC,
   parameter int CHECK_STOP   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    din,
   output logic [PAYLOAD_BITS-1:0] data_out,
   output logic                    data_valid,
   output logic                    err_timeout,
   output logic                    err_timing,
   output logic                    err_stop,
   output logic [15:0]             frames_ok
);

   localparam int BW = $clog2(jb_max(HEAD_BITS, PAYLOAD_BITS) + 1);
   localparam logic [BW-1:0] HEAD_LAST =
      BW'((HEAD_BITS > 0) ? HEAD_BITS - 1 : 0);
   localparam logic [BW-1:0] PAY_LAST = BW'(PAYLOAD_BITS - 1);

   if (SAMPLE_CYC < 1 || SAMPLE_CYC >= TIMEOUT_CYC || HEAD_BITS < 0 ||
       PAYLOAD_BITS < 1 || PAYLOAD_BITS > 64) begin : g_bad_params
      $error("joybus_frame_rx: illegal parameter set");
   end

   jb_state_e               state_q;
   logic [BW-1:0]           bit_cnt_q;
   logic                    sampled_q;
   logic [PAYLOAD_BITS-1:0] shift_q;
   logic [PAYLOAD_BITS-1:0] data_q;
   logic                    valid_q;
   logic                    tout_q;
   logic                    tim_q;
   logic                    stop_q;
   logic [15:0]             frames_q;

   logic                    fall;
   logic                    smp_stb;
   logic                    smp_val;
   logic                    tout;
   logic                    active;
   logic [PAYLOAD_BITS:0]   shift_ext;

   assign active    = (state_q != JB_S_IDLE);
   assign shift_ext = {smp_val, shift_q};

   joybus_bit_sampler #(
      .SAMPLE_CYC  (SAMPLE_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_sampler (
      .clk          (clk),
      .reset        (reset),
      .din_i        (din),
      .active_i     (active),
      .fall_o       (fall),
      .sample_stb_o (smp_stb),
      .sample_val_o (smp_val),
      .timeout_o    (tout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= JB_S_IDLE;
         bit_cnt_q <= '0;
         sampled_q <= 1'b0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         tout_q    <= 1'b0;
         tim_q     <= 1'b0;
         stop_q    <= 1'b0;
         frames_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         tout_q  <= 1'b0;
         tim_q   <= 1'b0;
         stop_q  <= 1'b0;
         unique case (state_q)
            JB_S_IDLE: begin
               if (fall) begin
                  bit_cnt_q <= '0;
                  sampled_q <= 1'b0;
                  state_q   <= (HEAD_BITS == 0) ? JB_S_PAYLOAD : JB_S_HEAD;
               end
            end
            JB_S_HEAD, JB_S_PAYLOAD, JB_S_STOP: begin
               // timing error outranks a coincident timeout
               if (fall && !sampled_q) begin
                  tim_q   <= 1'b1;
                  state_q <= JB_S_IDLE;
               end else if (tout) begin
                  tout_q  <= 1'b1;
                  state_q <= JB_S_IDLE;
               end else if (fall) begin
                  sampled_q <= 1'b0;
               end else if (smp_stb && !sampled_q) begin
                  sampled_q <= 1'b1;
                  if (state_q == JB_S_HEAD) begin
                     if (bit_cnt_q == HEAD_LAST) begin
                        bit_cnt_q <= '0;
                        state_q   <= JB_S_PAYLOAD;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                     end
                  end else if (state_q == JB_S_PAYLOAD) begin
                     shift_q <= shift_ext[PAYLOAD_BITS:1];
                     if (bit_cnt_q == PAY_LAST) begin
                        state_q <= (CHECK_STOP != 0) ? JB_S_STOP : JB_S_DONE;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                     end
                  end else if (smp_val) begin
                     state_q <= JB_S_DONE;
                  end else begin
                     stop_q  <= 1'b1;
                     state_q <= JB_S_IDLE;
                  end
               end
            end
            JB_S_DONE: begin
               data_q   <= shift_q;
               valid_q  <= 1'b1;
               frames_q <= frames_q + 16'd1;
               state_q  <= JB_S_IDLE;
            end
            default: state_q <= JB_S_IDLE;
         endcase
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign err_timeout = tout_q;
   assign err_timing  = tim_q;
   assign err_stop    = stop_q;
   assign frames_ok   = frames_q;

endmodule

// File: tb/tb_joybus_frame_rx.sv
// Directed bench for joybus_frame_rx: default, no-stop-check and
// 16-bit headerless fast-timing instances.
module tb_joybus_frame_rx;
   import joybus_frame_rx_pkg::*;

   logic clk = 1'b0;
   logic rst_ab = 1'b1;
   logic rst_c = 1'b1;
   logic line_ab = 1'b1;
   logic line_c = 1'b1;
   logic en_a = 1'b1;
   logic en_b = 1'b0;
   logic din_a;
   logic din_b;

   assign din_a = en_a ? line_ab : 1'b1;
   assign din_b = en_b ? line_ab : 1'b1;

   logic [31:0] data_out_a, data_out_b;
   logic [15:0] data_out_c;
   logic        data_valid_a, data_valid_b, data_valid_c;
   logic        err_timeout_a, err_timeout_b, err_timeout_c;
   logic        err_timing_a, err_timing_b, err_timing_c;
   logic        err_stop_a, err_stop_b, err_stop_c;
   logic [15:0] frames_ok_a, frames_ok_b, frames_ok_c;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   joybus_frame_rx dut_a (
      .clk(clk), .reset(rst_ab), .din(din_a),
      .data_out(data_out_a), .data_valid(data_valid_a),
      .err_timeout(err_timeout_a), .err_timing(err_timing_a),
      .err_stop(err_stop_a), .frames_ok(frames_ok_a)
   );

   joybus_frame_rx #(.CHECK_STOP(0)) dut_b (
      .clk(clk), .reset(rst_ab), .din(din_b),
      .data_out(data_out_b), .data_valid(data_valid_b),
      .err_timeout(err_timeout_b), .err_timing(err_timing_b),
      .err_stop(err_stop_b), .frames_ok(frames_ok_b)
   );

   joybus_frame_rx #(
      .HEAD_BITS(0), .PAYLOAD_BITS(16),
      .SAMPLE_CYC(4), .TIMEOUT_CYC(10)
   ) dut_c (
      .clk(clk), .reset(rst_c), .din(line_c),
      .data_out(data_out_c), .data_valid(data_valid_c),
      .err_timeout(err_timeout_c), .err_timing(err_timing_c),
      .err_stop(err_stop_c), .frames_ok(frames_ok_c)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_word(input int i);
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   int n_val_a = 0, n_tout_a = 0, n_tim_a = 0, n_stop_a = 0;
   int n_val_b = 0, n_err_b = 0, n_err_c = 0, rx_c = 0;

   always @(negedge clk) begin
      if (data_valid_a) n_val_a <= n_val_a + 1;
      if (err_timeout_a) n_tout_a <= n_tout_a + 1;
      if (err_timing_a) n_tim_a <= n_tim_a + 1;
      if (err_stop_a) n_stop_a <= n_stop_a + 1;
      if (data_valid_b) n_val_b <= n_val_b + 1;
      if (err_timeout_b | err_timing_b | err_stop_b) n_err_b <= n_err_b + 1;
      if (err_timeout_c | err_timing_c | err_stop_c) n_err_c <= n_err_c + 1;
      if (data_valid_c) begin
         chk("t6_data", 64'(data_out_c), 64'(ref_word(rx_c)));
         rx_c <= rx_c + 1;
      end
   end

   // 4 us bit: 1 us low for a one, 3 us low for a zero
   task automatic bit_ab(input logic b);
      line_ab = 1'b0;
      repeat (b ? 50 : 150) @(negedge clk);
      line_ab = 1'b1;
      repeat (b ? 150 : 50) @(negedge clk);
   endtask

   task automatic word_ab(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) bit_ab(v[i]);
   endtask

   task automatic head_ab();
      logic [7:0] cmd;
      cmd = JB_CMD_POLL;
      for (int i = 7; i >= 0; i--) bit_ab(cmd[i]);
      bit_ab(1'b1);
   endtask

   task automatic bit_c(input logic b);
      line_c = 1'b0;
      repeat (b ? 2 : 6) @(negedge clk);
      line_c = 1'b1;
      repeat (b ? 6 : 2) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int t0, ts, o0, g0, s0, v0, e0;
      logic found;
      logic [15:0] w;
      repeat (4) @(negedge clk);
      chk("rst_data", 64'(data_out_a), 64'h0);
      chk("rst_valid", 64'(data_valid_a), 64'h0);
      chk("rst_frames", 64'(frames_ok_a), 64'h0);
      chk("rst_tout", 64'(err_timeout_a), 64'h0);
      chk("rst_timing", 64'(err_timing_a), 64'h0);
      chk("rst_stop", 64'(err_stop_a), 64'h0);
      chk("rst_frames_c", 64'(frames_ok_c), 64'h0);
      rst_ab = 1'b0;
      rst_c = 1'b0;
      @(negedge clk);
      fork
         begin
            for (int i = 0; i < 260; i++) begin
               w = ref_word(i);
               for (int k = 0; k < 16; k++) bit_c(w[k]);
               bit_c(1'b1);
            end
            idle(20);
            chk("t6_frames", 64'(frames_ok_c), 64'd260);
            chk("t6_rx", 64'(rx_c), 64'd260);
            chk("t6_errs", 64'(n_err_c), 64'd0);
         end
         begin
            head_ab();
            word_ab(64'h8001_00FF, 32);
            bit_ab(1'b1);
            idle(20);
            chk("t1_valid", 64'(n_val_a), 64'd1);
            chk("t1_data", 64'(data_out_a), 64'h8001_00FF);
            chk("t1_frames", 64'(frames_ok_a), 64'd1);
            chk("t1_errs", 64'(n_tout_a + n_tim_a + n_stop_a), 64'd0);

            o0 = n_tout_a;
            head_ab();
            word_ab(64'hABC, 11);
            t0 = cyc;
            line_ab = 1'b0;
            idle(50);
            line_ab = 1'b1;
            found = 1'b0;
            ts = 0;
            for (int k = 0; k < 400 && !found; k++) begin
               @(negedge clk);
               if (err_timeout_a) begin
                  found = 1'b1;
                  ts = cyc;
               end
            end
            chk("t2_seen", 64'(found), 64'd1);
            // 2 sync stages + 250 timer cycles + registered pulse
            chk("t2_latency", 64'(ts - t0), 64'd253);
            idle(20);
            chk("t2_tout_cnt", 64'(n_tout_a - o0), 64'd1);
            chk("t2_hold", 64'(data_out_a), 64'h8001_00FF);
            chk("t2_frames", 64'(frames_ok_a), 64'd1);

            g0 = n_tim_a;
            o0 = n_tout_a;
            head_ab();
            word_ab(64'h5, 3);
            line_ab = 1'b0;
            idle(20);
            line_ab = 1'b1;
            idle(20);
            line_ab = 1'b0;
            idle(20);
            line_ab = 1'b1;
            idle(400);
            chk("t3_timing", 64'(n_tim_a - g0), 64'd1);
            chk("t3_no_tout", 64'(n_tout_a - o0), 64'd0);
            head_ab();
            word_ab(64'h0F0F_A5C3, 32);
            bit_ab(1'b1);
            idle(20);
            chk("t3_data", 64'(data_out_a), 64'h0F0F_A5C3);
            chk("t3_frames", 64'(frames_ok_a), 64'd2);

            v0 = n_val_a;
            s0 = n_stop_a;
            en_b = 1'b1;
            head_ab();
            word_ab(64'hDEAD_BEEF, 32);
            bit_ab(1'b0);
            idle(400);
            en_b = 1'b0;
            chk("t4_stop", 64'(n_stop_a - s0), 64'd1);
            chk("t4_novalid", 64'(n_val_a - v0), 64'd0);
            chk("t4_hold", 64'(data_out_a), 64'h0F0F_A5C3);
            chk("t4_frames", 64'(frames_ok_a), 64'd2);
            chk("t4_b_valid", 64'(n_val_b), 64'd1);
            chk("t4_b_data", 64'(data_out_b), 64'hDEAD_BEEF);
            chk("t4_b_frames", 64'(frames_ok_b), 64'd1);

            head_ab();
            word_ab(64'h3FF, 10);
            rst_ab = 1'b1;
            @(negedge clk);
            rst_ab = 1'b0;
            e0 = n_tout_a + n_tim_a + n_stop_a;
            chk("t5_data", 64'(data_out_a), 64'h0);
            chk("t5_frames", 64'(frames_ok_a), 64'h0);
            chk("t5_valid", 64'(data_valid_a), 64'h0);
            idle(400);
            chk("t5_no_err", 64'(n_tout_a + n_tim_a + n_stop_a - e0), 64'd0);
            head_ab();
            word_ab(64'h7E81_3C42, 32);
            bit_ab(1'b1);
            idle(20);
            chk("t5_data2", 64'(data_out_a), 64'h7E81_3C42);
            chk("t5_frames2", 64'(frames_ok_a), 64'd1);
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
